// File: rtl/dg0050_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dg0050_pkg
// Purpose  : Shared types and defaults for the dg0050 return-address stack:
//            stack operation encoding, per-cell mux select and default sizes.
// Revision : 1.0 - initial release
// ============================================================================
package dg0050_pkg;

  localparam int c_default_addr_w = 10;
  localparam int c_default_depth  = 5;

  // Stack operation, encoded directly as {push, pop}
  typedef enum logic [1:0] {
    NONE    = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    REPLACE = 2'b11
  } stack_op_e;

  // Per-cell next-value source
  typedef enum logic [1:0] {
    CELL_HOLD       = 2'b00,
    CELL_LOAD       = 2'b01,
    CELL_FROM_ABOVE = 2'b10,
    CELL_FROM_BELOW = 2'b11
  } cell_sel_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage
`default_nettype wire

// File: rtl/dg0050_stack_cell.sv
`default_nettype none
// ============================================================================
// Module   : dg0050_stack_cell
// Purpose  : One stack entry: an ADDR_W register whose next value is chosen
//            from hold / load / entry above / entry below.
// Revision : 1.0 - initial release
// ============================================================================
module dg0050_stack_cell
  import dg0050_pkg::*;
#(
  parameter int ADDR_W = c_default_addr_w
) (
  input  logic              clk,
  input  logic              rst_n,
  input  cell_sel_e         sel,
  input  logic [ADDR_W-1:0] load_val,
  input  logic [ADDR_W-1:0] from_above,
  input  logic [ADDR_W-1:0] from_below,
  output logic [ADDR_W-1:0] q
);

  logic [ADDR_W-1:0] r_q;

  // Entry register with four-way next-value mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      case (sel)
        CELL_LOAD:       r_q <= load_val;
        CELL_FROM_ABOVE: r_q <= from_above;
        CELL_FROM_BELOW: r_q <= from_below;
        default:         r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/dg0050_pc_stack.sv
`default_nettype none
// ============================================================================
// Module   : dg0050_pc_stack
// Purpose  : Shift-structured return-address stack (CALL/RET) with saturating
//            occupancy count and optional sticky overflow/underflow flags.
//            Define DG0050_PC_STACK_ERR_FLAGS_EN to build the ovf/unf flags;
//            otherwise they are tied low and clr_err is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module dg0050_pc_stack
  import dg0050_pkg::*;
#(
  parameter int ADDR_W = c_default_addr_w,
  parameter int DEPTH  = c_default_depth
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       clr_err,
  output logic [ADDR_W-1:0]          top_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int                 c_cnt_w = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  stack_op_e          w_op;
  logic [c_cnt_w-1:0] r_count;
  logic               w_empty;
  logic               w_full;
  logic [ADDR_W-1:0]  w_e [DEPTH];

  assign w_op    = decode_op(push, pop);
  // Status comes only from the registered count, never from the inputs
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);

  // Entry 0 is the top; higher indices are older return addresses
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      logic [ADDR_W-1:0] w_above;
      logic [ADDR_W-1:0] w_below;
      cell_sel_e         w_sel;

      if (i == 0) begin : g_top
        assign w_above = w_e[0];
      end else begin : g_inner_above
        assign w_above = w_e[i-1];
      end

      // Bottom entry feeds itself so a pop duplicates it
      if (i == DEPTH - 1) begin : g_bottom
        assign w_below = w_e[i];
      end else begin : g_inner_below
        assign w_below = w_e[i+1];
      end

      // Select this entry's next-value source from the decoded operation
      always_comb begin
        w_sel = CELL_HOLD;
        case (w_op)
          PUSH: begin
            if (i == 0) w_sel = CELL_LOAD;
            else        w_sel = CELL_FROM_ABOVE;
          end
          REPLACE: begin
            if (i == 0) w_sel = CELL_LOAD;
          end
          POP: begin
            if (!w_empty) w_sel = CELL_FROM_BELOW;
          end
          default: w_sel = CELL_HOLD;
        endcase
      end

      dg0050_stack_cell #(
        .ADDR_W (ADDR_W)
      ) u_cell (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (w_sel),
        .load_val   (push_addr),
        .from_above (w_above),
        .from_below (w_below),
        .q          (w_e[i])
      );
    end
  endgenerate

  // Occupancy: saturating increment on push, guarded decrement on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case (w_op)
        PUSH:    if (!w_full)  r_count <= r_count + c_one;
        POP:     if (!w_empty) r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef DG0050_PC_STACK_ERR_FLAGS_EN
  logic r_ovf;
  logic r_unf;

  // Sticky error flags; a new error outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if ((w_op == PUSH) && w_full)      r_ovf <= 1'b1;
      else if (clr_err)                  r_ovf <= 1'b0;
      if ((w_op == POP) && w_empty)      r_unf <= 1'b1;
      else if (clr_err)                  r_unf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
  assign unf = r_unf;
`else
  logic w_unused_clr_err;

  assign w_unused_clr_err = clr_err;
  assign ovf              = 1'b0;
  assign unf              = 1'b0;
`endif

  assign top_addr = w_e[0];
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;

endmodule
`default_nettype wire

// File: tb/tb_dg0050_pc_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_dg0050_pc_stack
// Purpose  : Self-checking bench for dg0050_pc_stack (ADDR_W=10, DEPTH=5).
//            Expected ovf/unf follow DG0050_PC_STACK_ERR_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dg0050_pc_stack;

`ifdef DG0050_PC_STACK_ERR_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic [9:0] push_addr;
  logic       clr_err;
  logic [9:0] top_addr;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       ovf;
  logic       unf;

  typedef struct {
    logic [9:0] top;
    logic [2:0] cnt;
    logic       eo;
    logic       eu;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  dg0050_pc_stack #(
    .ADDR_W (10),
    .DEPTH  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .clr_err   (clr_err),
    .top_addr  (top_addr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    logic [15:0] act;
    logic [15:0] req;
    act = {top_addr, count, empty, full, ovf, unf};
    req = {e.top, e.cnt, (e.cnt == 3'd0), (e.cnt == 3'd5), e.eo, e.eu};
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got top=%h cnt=%0d emp=%b full=%b ovf=%b unf=%b, want top=%h cnt=%0d emp=%b full=%b ovf=%b unf=%b",
               e.nm, top_addr, count, empty, full, ovf, unf,
               e.top, e.cnt, (e.cnt == 3'd0), (e.cnt == 3'd5), e.eo, e.eu);
    end
  endtask

  // Monitor: every edge with an outstanding expectation is checked
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e);
      end
    end
  end

  task automatic step(input logic p, input logic o, input logic [9:0] a,
                      input logic c, input logic [9:0] et, input logic [2:0] ec,
                      input logic eo, input logic eu, input string nm);
    @(negedge clk);
    rst_n     = 1'b1;
    push      = p;
    pop       = o;
    push_addr = a;
    clr_err   = c;
    q.push_back('{et, ec, eo, eu, nm});
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0; clr_err = 1'b0;
    #2;
    check('{10'h000, 3'd0, 1'b0, 1'b0, "reset_state"});
    repeat (2) @(posedge clk);

    // Three calls then three returns
    step(1, 0, 10'h3C1, 0, 10'h3C1, 3'd1, 0, 0, "push_3c1");
    step(1, 0, 10'h3C2, 0, 10'h3C2, 3'd2, 0, 0, "push_3c2");
    step(1, 0, 10'h3C3, 0, 10'h3C3, 3'd3, 0, 0, "push_3c3");
    step(0, 1, 10'h000, 0, 10'h3C2, 3'd2, 0, 0, "pop_a");
    step(0, 1, 10'h000, 0, 10'h3C1, 3'd1, 0, 0, "pop_b");
    step(0, 1, 10'h000, 0, 10'h000, 3'd0, 0, 0, "pop_c");

    // Underflow, stickiness, clear, set-beats-clear
    step(0, 1, 10'h000, 0, 10'h000, 3'd0, 0, FL, "pop_empty");
    step(0, 0, 10'h000, 0, 10'h000, 3'd0, 0, FL, "unf_sticky");
    step(0, 0, 10'h000, 1, 10'h000, 3'd0, 0, 0,  "clr_unf");
    step(0, 1, 10'h000, 1, 10'h000, 3'd0, 0, FL, "unf_set_wins");
    step(0, 0, 10'h000, 1, 10'h000, 3'd0, 0, 0,  "clr_unf2");

    // Fill past DEPTH: oldest entry is lost
    step(1, 0, 10'h001, 0, 10'h001, 3'd1, 0, 0, "fill_1");
    step(1, 0, 10'h002, 0, 10'h002, 3'd2, 0, 0, "fill_2");
    step(1, 0, 10'h003, 0, 10'h003, 3'd3, 0, 0, "fill_3");
    step(1, 0, 10'h004, 0, 10'h004, 3'd4, 0, 0, "fill_4");
    step(1, 0, 10'h005, 0, 10'h005, 3'd5, 0, 0, "fill_5");
    step(1, 0, 10'h006, 0, 10'h006, 3'd5, FL, 0, "push_full");
    step(0, 1, 10'h000, 0, 10'h005, 3'd4, FL, 0, "drain_1");
    step(0, 1, 10'h000, 0, 10'h004, 3'd3, FL, 0, "drain_2");
    step(0, 1, 10'h000, 0, 10'h003, 3'd2, FL, 0, "drain_3");
    step(0, 1, 10'h000, 0, 10'h002, 3'd1, FL, 0, "drain_4");
    step(0, 1, 10'h000, 0, 10'h002, 3'd0, FL, 0, "drain_5");
    step(0, 0, 10'h000, 1, 10'h002, 3'd0, 0, 0,  "clr_ovf");

    // Replace keeps count and lower entries
    step(1, 0, 10'h100, 0, 10'h100, 3'd1, 0, 0, "push_100");
    step(1, 0, 10'h2A0, 0, 10'h2A0, 3'd2, 0, 0, "push_2a0");
    step(1, 1, 10'h155, 0, 10'h155, 3'd2, 0, 0, "replace_mid");
    step(0, 1, 10'h000, 0, 10'h100, 3'd1, 0, 0, "pop_after_repl");
    step(0, 1, 10'h000, 0, 10'h002, 3'd0, 0, 0, "pop_to_empty");
    step(1, 1, 10'h3FF, 0, 10'h3FF, 3'd0, 0, 0, "replace_empty");
    step(1, 0, 10'h00A, 0, 10'h00A, 3'd1, 0, 0, "push_a");
    step(1, 0, 10'h00B, 0, 10'h00B, 3'd2, 0, 0, "push_b");
    step(1, 0, 10'h00C, 0, 10'h00C, 3'd3, 0, 0, "push_c");
    step(1, 0, 10'h00D, 0, 10'h00D, 3'd4, 0, 0, "push_d");
    step(1, 0, 10'h00E, 0, 10'h00E, 3'd5, 0, 0, "push_e");
    step(1, 1, 10'h3AA, 0, 10'h3AA, 3'd5, 0, 0, "replace_full");
    step(1, 0, 10'h3BB, 0, 10'h3BB, 3'd5, FL, 0, "ovf_again");
    step(0, 1, 10'h000, 0, 10'h3AA, 3'd4, FL, 0, "pop_to_4");

    // Reset lands between a push and its clock edge
    @(negedge clk);
    push = 1'b1; pop = 1'b0; push_addr = 10'h111; clr_err = 1'b0;
    q.push_back('{10'h000, 3'd0, 1'b0, 1'b0, "reset_edge"});
    #2;
    rst_n = 1'b0;
    #1;
    check('{10'h000, 3'd0, 1'b0, 1'b0, "async_reset"});
    step(1, 0, 10'h0FF, 0, 10'h0FF, 3'd1, 0, 0, "push_after_rst");
    step(0, 0, 10'h000, 0, 10'h0FF, 3'd1, 0, 0, "idle_hold");

    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
